// File: rtl/ddr_pkg.sv
// Shared definitions for the DDR burst master: FSM encoding, data-path
// constants and the default burst/address/region geometry.
package ddr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_BURST = 2'd1,
    ST_RD_CMD   = 2'd2,
    ST_RD_WAIT  = 2'd3
  } ddr_state_e;

  localparam int         DDR_DATA_W = 32;
  localparam logic [3:0] DDR_BE_ALL = 4'hF;
  localparam int         DDR_BASE_W = 24;

  localparam int DDR_BURST_DEF        = 4;
  localparam int DDR_ADDR_W_DEF       = 25;
  localparam int DDR_REGION_WORDS_DEF = 1 << 20;

endpackage

// File: rtl/ddr_addr_stream.sv
// Sequential burst address generator: latches a region base, keeps a
// burst-aligned offset that wraps at the end of the region, and presents
// base + offset (modulo 2^ADDR_W).
module ddr_addr_stream
  import ddr_pkg::*;
#(
  parameter int ADDR_W       = DDR_ADDR_W_DEF,
  parameter int BURST        = DDR_BURST_DEF,
  parameter int REGION_WORDS = DDR_REGION_WORDS_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reload_i,
  input  logic                  advance_i,
  input  logic [DDR_BASE_W-1:0] base_i,
  output logic [ADDR_W-1:0]     addr_o
);

  // Offset only ever holds values below REGION_WORDS.
  localparam int               OFF_W    = $clog2(REGION_WORDS) + 1;
  localparam logic [OFF_W-1:0] OFF_STEP = OFF_W'(BURST);
  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(REGION_WORDS - BURST);

  logic [ADDR_W-1:0] base_q, base_d;
  logic [OFF_W-1:0]  off_q, off_d;

  // Reload wins over advance; advance wraps the last burst slot back to 0.
  always_comb begin
    base_d = base_q;
    off_d  = off_q;
    if (reload_i) begin
      base_d = ADDR_W'(base_i);
      off_d  = '0;
    end else if (advance_i) begin
      off_d = (off_q == OFF_LAST) ? '0 : off_q + OFF_STEP;
    end
  end

  // Base and offset registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q <= '0;
      off_q  <= '0;
    end else begin
      base_q <= base_d;
      off_q  <= off_d;
    end
  end

  assign addr_o = base_q + ADDR_W'(off_q);

endmodule

// File: rtl/ddr_burst_master.sv
// DDR burst master: drains the write FIFO into DDR and refills the read FIFO
// from DDR in fixed-length bursts, one burst in flight at a time.
// Optional feature: define DDR_BURST_MASTER_RR_EN for round-robin
// arbitration between write and read when both are eligible; otherwise
// writes always win.
module ddr_burst_master
  import ddr_pkg::*;
#(
  parameter int BURST        = DDR_BURST_DEF,
  parameter int ADDR_W       = DDR_ADDR_W_DEF,
  parameter int REGION_WORDS = DDR_REGION_WORDS_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DDR_BASE_W-1:0] rd_start_addr,
  input  logic [DDR_BASE_W-1:0] wr_start_addr,
  input  logic                  wf_ready,
  input  logic [DDR_DATA_W-1:0] wf_q,
  output logic                  wf_rdreq,
  input  logic                  rf_room,
  output logic                  rf_wrreq,
  output logic [DDR_DATA_W-1:0] rf_data,
  input  logic                  local_init_done,
  input  logic                  local_ready,
  output logic [ADDR_W-1:0]     local_address,
  output logic                  local_burstbegin,
  output logic [2:0]            local_size,
  output logic [3:0]            local_be,
  output logic                  local_write_req,
  output logic [DDR_DATA_W-1:0] local_wdata,
  output logic                  local_read_req,
  input  logic [DDR_DATA_W-1:0] local_rdata,
  input  logic                  local_rdata_valid,
  output logic                  wr_addr_up,
  output logic                  rd_addr_up,
  output logic                  busy
);

  localparam int               CNT_W     = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(BURST - 1);

  ddr_state_e            state_q;
  logic                  wr_req_q, rd_req_q, bb_q;
  logic [CNT_W-1:0]      beat_q;
  logic                  pend_q;
  logic                  wr_up_q, rd_up_q;
  logic                  rf_wrreq_q;
  logic [DDR_DATA_W-1:0] rf_data_q;
`ifdef DDR_BURST_MASTER_RR_EN
  logic                  last_wr_q;
`endif

  logic              wr_accept, wr_done, rd_beat, rd_done, reload;
  logic              grant_wr, grant_rd;
  logic [ADDR_W-1:0] wr_addr, rd_addr;

  assign wr_accept = wr_req_q & local_ready;
  assign wr_done   = (state_q == ST_WR_BURST) & local_ready & (beat_q == BEAT_LAST);
  assign rd_beat   = (state_q == ST_RD_WAIT) & local_rdata_valid;
  assign rd_done   = rd_beat & (beat_q == BEAT_LAST);
  // A start seen mid-burst is held in pend_q and applied on the IDLE cycle,
  // so the new address is in place before the next burst's first request.
  assign reload    = (state_q == ST_IDLE) & (start | pend_q);

  // Pick the next burst direction while idle and calibrated.
  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (state_q == ST_IDLE && local_init_done) begin
`ifdef DDR_BURST_MASTER_RR_EN
      if (wf_ready && rf_room) begin
        grant_wr = ~last_wr_q;
        grant_rd = last_wr_q;
      end else begin
        grant_wr = wf_ready;
        grant_rd = rf_room;
      end
`else
      grant_wr = wf_ready;
      grant_rd = rf_room & ~wf_ready;
`endif
    end
  end

  // Burst sequencer with registered request/strobe outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      wr_req_q <= 1'b0;
      rd_req_q <= 1'b0;
      bb_q     <= 1'b0;
      beat_q   <= '0;
      pend_q   <= 1'b0;
      wr_up_q  <= 1'b0;
      rd_up_q  <= 1'b0;
`ifdef DDR_BURST_MASTER_RR_EN
      last_wr_q <= 1'b0;
`endif
    end else begin
      wr_up_q <= wr_done;
      rd_up_q <= rd_done;
      if (state_q == ST_IDLE)
        pend_q <= 1'b0;
      else if (start)
        pend_q <= 1'b1;
`ifdef DDR_BURST_MASTER_RR_EN
      if (grant_wr)
        last_wr_q <= 1'b1;
      else if (grant_rd)
        last_wr_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          beat_q <= '0;
          if (grant_wr) begin
            state_q  <= ST_WR_BURST;
            wr_req_q <= 1'b1;
            bb_q     <= 1'b1;
          end else if (grant_rd) begin
            state_q  <= ST_RD_CMD;
            rd_req_q <= 1'b1;
            bb_q     <= 1'b1;
          end
        end
        ST_WR_BURST: begin
          if (local_ready) begin
            bb_q   <= 1'b0;
            beat_q <= beat_q + 1'b1;
            if (beat_q == BEAT_LAST) begin
              state_q  <= ST_IDLE;
              wr_req_q <= 1'b0;
            end
          end
        end
        ST_RD_CMD: begin
          if (local_ready) begin
            state_q  <= ST_RD_WAIT;
            rd_req_q <= 1'b0;
            bb_q     <= 1'b0;
          end
        end
        ST_RD_WAIT: begin
          if (local_rdata_valid) begin
            beat_q <= beat_q + 1'b1;
            if (beat_q == BEAT_LAST)
              state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Register each returned read beat toward the read FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_wrreq_q <= 1'b0;
      rf_data_q  <= '0;
    end else begin
      rf_wrreq_q <= rd_beat;
      if (rd_beat)
        rf_data_q <= local_rdata;
    end
  end

  ddr_addr_stream #(
    .ADDR_W       (ADDR_W),
    .BURST        (BURST),
    .REGION_WORDS (REGION_WORDS)
  ) u_wr_stream (
    .clk       (clk),
    .reset     (reset),
    .reload_i  (reload),
    .advance_i (wr_done),
    .base_i    (wr_start_addr),
    .addr_o    (wr_addr)
  );

  ddr_addr_stream #(
    .ADDR_W       (ADDR_W),
    .BURST        (BURST),
    .REGION_WORDS (REGION_WORDS)
  ) u_rd_stream (
    .clk       (clk),
    .reset     (reset),
    .reload_i  (reload),
    .advance_i (rd_done),
    .base_i    (rd_start_addr),
    .addr_o    (rd_addr)
  );

  assign wf_rdreq         = wr_accept;
  assign local_write_req  = wr_req_q;
  assign local_read_req   = rd_req_q;
  assign local_burstbegin = bb_q;
  assign local_address    = (state_q == ST_RD_CMD || state_q == ST_RD_WAIT) ? rd_addr : wr_addr;
  assign local_wdata      = wf_q;
  assign local_size       = 3'(BURST);
  assign local_be         = DDR_BE_ALL;
  assign rf_wrreq         = rf_wrreq_q;
  assign rf_data          = rf_data_q;
  assign wr_addr_up       = wr_up_q;
  assign rd_addr_up       = rd_up_q;
  assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ddr_burst_master.sv
// Scoreboard bench for ddr_burst_master (region shrunk to 8 words so that
// address wrap shows up after two bursts). Expected bursts, addresses and
// data are queued by the stimulus; a negedge monitor pops and compares.
module tb_ddr_burst_master;
  localparam int AW = 25;
  localparam logic [7:0] OW = 8'h57;
  localparam logic [7:0] OR = 8'h52;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start;
  logic [23:0]   rd_start_addr, wr_start_addr;
  logic          wf_ready, wf_rdreq, rf_room, rf_wrreq;
  logic [31:0]   wf_q, rf_data, local_wdata, local_rdata;
  logic          local_init_done, local_ready, local_burstbegin;
  logic [AW-1:0] local_address;
  logic [2:0]    local_size;
  logic [3:0]    local_be;
  logic          local_write_req, local_read_req, local_rdata_valid;
  logic          wr_addr_up, rd_addr_up, busy;

  ddr_burst_master #(.BURST(4), .ADDR_W(AW), .REGION_WORDS(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rd_start_addr(rd_start_addr), .wr_start_addr(wr_start_addr),
    .wf_ready(wf_ready), .wf_q(wf_q), .wf_rdreq(wf_rdreq),
    .rf_room(rf_room), .rf_wrreq(rf_wrreq), .rf_data(rf_data),
    .local_init_done(local_init_done), .local_ready(local_ready),
    .local_address(local_address), .local_burstbegin(local_burstbegin),
    .local_size(local_size), .local_be(local_be),
    .local_write_req(local_write_req), .local_wdata(local_wdata),
    .local_read_req(local_read_req), .local_rdata(local_rdata),
    .local_rdata_valid(local_rdata_valid),
    .wr_addr_up(wr_addr_up), .rd_addr_up(rd_addr_up), .busy(busy)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wexp_t;

  int total = 0;
  int bad   = 0;

  wexp_t         exp_wr[$];
  logic [AW-1:0] exp_rd[$];
  logic [31:0]   exp_rf[$];
  logic [7:0]    exp_order[$];
  logic [31:0]   wq[$];

  int          wval = 1;
  logic [31:0] rval = 32'hA0;
  bit          wf_en = 1'b0;
  int          rd_cmds = 0;
  int          rd_stop = 1000;
  int          rsp_cnt = 0;
  bit          stray_go = 1'b0;
  bit          stray_done = 1'b0;
  int          wr_up_cnt = 0;
  int          rd_up_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic order_check(input logic [7:0] kind);
    logic [7:0] head;
    head = 8'h00;
    if (exp_order.size() > 0) head = exp_order.pop_front();
    chk("burst_order", 32'(kind), 32'(head));
  endtask

  // Queue one write burst: four FIFO words plus the beats expected at addr a.
  task automatic exp_write(input logic [AW-1:0] a);
    wexp_t e;
    for (int k = 0; k < 4; k++) begin
      wq.push_back(32'(wval));
      e.addr = a;
      e.data = 32'(wval);
      exp_wr.push_back(e);
      wval++;
    end
    exp_order.push_back(OW);
  endtask

  // Queue one read burst: the command at addr a and the four pushes it yields.
  task automatic exp_read(input logic [AW-1:0] a);
    exp_rd.push_back(a);
    exp_order.push_back(OR);
    for (int k = 0; k < 4; k++) begin
      exp_rf.push_back(rval);
      rval = rval + 32'd1;
    end
  endtask

  task automatic pulse_start;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic drain(input int budget, input bit toggle);
    int n;
    n = 0;
    while ((exp_wr.size() + exp_rd.size() + exp_rf.size() + exp_order.size()) > 0 && n < budget) begin
      @(posedge clk); #1;
      if (toggle) local_ready = ~local_ready;
      if (rd_cmds >= rd_stop) rf_room = 1'b0;
      n++;
    end
    chk("drain_queues_empty", 32'(exp_wr.size() + exp_rd.size() + exp_rf.size() + exp_order.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1 local_ready = 1'b1;
  endtask

  // Show-ahead write FIFO model.
  initial begin
    bit p;
    logic [31:0] dummy;
    wf_q = 32'h0;
    wf_ready = 1'b0;
    forever begin
      @(negedge clk);
      p = wf_rdreq;
      @(posedge clk);
      #1;
      if (p && wq.size() > 0) dummy = wq.pop_front();
      wf_q = (wq.size() > 0) ? wq[0] : 32'h0;
      wf_ready = wf_en && (wq.size() >= 4);
    end
  end

  // DDR read responder: four beats with one idle gap; also emits a stray beat on request.
  initial begin
    local_rdata_valid = 1'b0;
    local_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!reset && local_read_req && local_ready) begin
        for (int k = 0; k < 5; k++) begin
          @(posedge clk); #1;
          if (k == 2) begin
            local_rdata_valid = 1'b0;
          end else begin
            local_rdata_valid = 1'b1;
            local_rdata = 32'hA0 + 32'(rsp_cnt);
            rsp_cnt++;
          end
        end
        @(posedge clk); #1 local_rdata_valid = 1'b0;
      end else if (stray_go && !stray_done) begin
        @(posedge clk); #1;
        local_rdata_valid = 1'b1;
        local_rdata = 32'hEE;
        @(posedge clk); #1 local_rdata_valid = 1'b0;
        stray_done = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  int          wr_acc = 0;
  logic        rdv_prev = 1'b0;
  logic [31:0] rdata_prev = 32'h0;
  always @(negedge clk) begin
    if (reset) begin
      wr_acc = 0;
      rdv_prev = 1'b0;
    end else begin
      if (local_write_req) chk("wr_burstbegin", 32'(local_burstbegin), 32'(wr_acc == 0));
      if (wf_rdreq) begin
        if (wr_acc == 0) order_check(OW);
        chk("wr_pop_expected", 32'(exp_wr.size() > 0), 32'd1);
        if (exp_wr.size() > 0) begin
          wexp_t e;
          e = exp_wr.pop_front();
          chk("wr_addr", 32'(local_address), 32'(e.addr));
          chk("wr_data", local_wdata, e.data);
        end
        wr_acc = (wr_acc == 3) ? 0 : wr_acc + 1;
      end
      if (local_read_req) chk("rd_burstbegin", 32'(local_burstbegin), 32'd1);
      if (local_read_req && local_ready) begin
        order_check(OR);
        chk("rd_cmd_expected", 32'(exp_rd.size() > 0), 32'd1);
        if (exp_rd.size() > 0) chk("rd_addr", 32'(local_address), 32'(exp_rd.pop_front()));
        rd_cmds++;
      end
      if (rf_wrreq) begin
        chk("rf_latency", 32'(rdv_prev), 32'd1);
        chk("rf_data_vs_prev_beat", rf_data, rdata_prev);
        chk("rf_push_expected", 32'(exp_rf.size() > 0), 32'd1);
        if (exp_rf.size() > 0) chk("rf_data", rf_data, exp_rf.pop_front());
      end
      wr_up_cnt += int'(wr_addr_up);
      rd_up_cnt += int'(rd_addr_up);
      rdv_prev = local_rdata_valid;
      rdata_prev = local_rdata;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    rd_start_addr = 24'h200;
    wr_start_addr = 24'h100;
    rf_room = 1'b0;
    local_init_done = 1'b0;
    local_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_write_req", 32'(local_write_req), 32'd0);
    chk("rst_read_req", 32'(local_read_req), 32'd0);
    chk("rst_burstbegin", 32'(local_burstbegin), 32'd0);
    chk("rst_wf_rdreq", 32'(wf_rdreq), 32'd0);
    chk("rst_rf_wrreq", 32'(rf_wrreq), 32'd0);
    chk("rst_rf_data", rf_data, 32'd0);
    chk("rst_address", 32'(local_address), 32'd0);
    chk("rst_addr_up", 32'({wr_addr_up, rd_addr_up}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_size", 32'(local_size), 32'd4);
    chk("rst_be", 32'(local_be), 32'hF);

    // Latch bases; no requests while calibration is pending.
    pulse_start();
    @(posedge clk); #1;
    exp_write(25'h100);
    wf_en = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("no_req_init_low", 32'({local_write_req, local_read_req}), 32'd0);
    end
    @(posedge clk); #1 local_init_done = 1'b1;
    drain(60, 1'b0);

    // Second burst continues sequentially.
    exp_write(25'h104);
    drain(60, 1'b0);

    // Backpressure: ready toggles; offset has wrapped back to the base.
    exp_write(25'h100);
    drain(80, 1'b1);

    // Read burst.
    exp_read(25'h200);
    rd_stop = rd_cmds + 1;
    rf_room = 1'b1;
    drain(80, 1'b0);
    chk("rd_addr_up_count", 32'(rd_up_cnt), 32'd1);

    // Stray read beat while idle must not push.
    stray_go = 1'b1;
    n = 0;
    while (!stray_done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("stray_emitted", 32'(stray_done), 32'd1);
    repeat (3) @(posedge clk);
    chk("rd_addr_up_after_stray", 32'(rd_up_cnt), 32'd1);

    // Wrap: base 0x10 in an 8-word region.
    wr_start_addr = 24'h10;
    pulse_start();
    @(posedge clk); #1;
    exp_write(25'h10);
    exp_write(25'h14);
    exp_write(25'h10);
    drain(120, 1'b0);

    // start mid-burst: current burst keeps 0x14, next uses the new base.
    wr_start_addr = 24'h40;
    exp_write(25'h14);
    exp_write(25'h40);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!local_write_req && n < 20);
    chk("busy_in_burst", 32'(busy), 32'd1);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    drain(80, 1'b0);

    // Contention: both sides eligible before calibration comes up.
    // Read offset was reloaded by the previous start; last served was a write.
    @(posedge clk); #1 local_init_done = 1'b0;
`ifdef DDR_BURST_MASTER_RR_EN
    exp_read(25'h200);
    exp_write(25'h44);
    exp_read(25'h204);
    exp_write(25'h40);
    rd_stop = rd_cmds + 2;
`else
    exp_write(25'h44);
    exp_write(25'h40);
    exp_read(25'h200);
    rd_stop = rd_cmds + 1;
`endif
    rf_room = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("no_req_init_low", 32'({local_write_req, local_read_req}), 32'd0);
    end
    @(posedge clk); #1 local_init_done = 1'b1;
    drain(200, 1'b0);

    chk("wr_addr_up_count", 32'(wr_up_cnt), 32'd10);
`ifdef DDR_BURST_MASTER_RR_EN
    chk("rd_addr_up_total", 32'(rd_up_cnt), 32'd3);
`else
    chk("rd_addr_up_total", 32'(rd_up_cnt), 32'd2);
`endif
    chk("idle_at_end", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ddr_burst_master.md
# ddr_burst_master

Burst engine between the DDR controller local interface and the pair of clock-crossing FIFOs in the DDR address top. It drains the write FIFO into DDR in fixed bursts and refills the read FIFO from DDR in fixed bursts. It generates both sequential address streams internally, each wrapping inside a configurable region. It runs entirely in the controller's phy clock domain and is the memory-side counterpart of the FIFO producer/consumer logic on the processing side.

## Interface
- BURST, 4: beats per burst; power of two, 1..7 legal on local_size.
- ADDR_W, 25: local address width in words.
- REGION_WORDS, 2^20: region length per stream; multiple of BURST.
- clk  in  1  phy clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; reload both address streams.
- rd_start_addr  in  24  read region base; zero-extended to ADDR_W.
- wr_start_addr  in  24  write region base; zero-extended to ADDR_W.
- wf_ready  in  1  write FIFO holds ≥ BURST words.
- wf_q  in  32  write FIFO head word; show-ahead.
- wf_rdreq  out  1  write FIFO pop.
- rf_room  in  1  read FIFO has ≥ BURST free words.
- rf_wrreq  out  1  read FIFO push.
- rf_data  out  32  read FIFO write data.
- local_init_done  in  1  controller calibrated.
- local_ready  in  1  controller accepts current command or beat.
- local_address  out  ADDR_W  burst address.
- local_burstbegin  out  1  first beat of a command.
- local_size  out  3  constant BURST.
- local_be  out  4  constant 4'hF.
- local_write_req  out  1  write command or beat valid.
- local_wdata  out  32  equals wf_q.
- local_read_req  out  1  read command valid.
- local_rdata  in  32  read data.
- local_rdata_valid  in  1  read data beat valid.
- wr_addr_up, rd_addr_up  out  1  one-cycle pulse when a burst completes.
- busy  out  1  FSM not in IDLE.

## Operation
- States: IDLE, WR_BURST, RD_CMD, RD_WAIT.
- IDLE, with local_init_done high:
  - wf_ready selects WR_BURST. Write has priority.
  - Otherwise rf_room selects RD_CMD.
  - Otherwise the FSM stays in IDLE.
  - While local_init_done is low, the FSM stays in IDLE.
- WR_BURST:
  - local_write_req=1 and local_address=wr_addr for the whole burst.
  - local_burstbegin=1 until the first beat is accepted.
  - A beat is accepted when local_ready=1. wf_rdreq is combinational: wf_rdreq = local_write_req & local_ready.
  - After BURST accepted beats: wr_addr advances, wr_addr_up pulses, the FSM returns to IDLE.
- RD_CMD:
  - local_read_req=1, local_burstbegin=1, local_address=rd_addr.
  - Held until local_ready=1, then go to RD_WAIT.
- RD_WAIT:
  - Count local_rdata_valid beats. Each beat is registered: rf_wrreq and rf_data follow one cycle later.
  - After BURST beats: rd_addr advances, rd_addr_up pulses, the FSM returns to IDLE.
  - Only one read burst is outstanding at a time.
- Address arithmetic:
  - Each stream keeps an offset. Address = base + offset, modulo 2^ADDR_W.
  - After a burst, offset += BURST. The offset wraps to 0 when it reaches REGION_WORDS.
- start:
  - In IDLE: both offsets clear to 0 and both bases re-latch on the next edge.
  - Otherwise it sets a pending flag. The reload is applied on the cycle the FSM enters IDLE, before the next arbitration. The in-flight burst always completes at its original address.
- local_rdata_valid outside RD_WAIT is ignored. No push is generated.

## Timing
- All outputs are 0 at reset except local_size=BURST and local_be=4'hF. Offsets, bases and the pending flag are cleared; the FSM is in IDLE.
- IDLE to the first request: 1 cycle. Requests are registered state decodes.
- Write burst with local_ready held high: BURST cycles, plus 1 IDLE cycle before the next arbitration.
- Read: local_rdata_valid to rf_wrreq latency is exactly 1 cycle.
- Reset asserted mid-burst aborts immediately. Partial FIFO pops are not undone; upstream FIFO aclr handles that.

## Configuration
- DDR_BURST_MASTER_RR_EN defined: round-robin arbitration. When both wf_ready and rf_room are set, grant the opposite of the last-served direction. The last-served flag resets to "read".
- DDR_BURST_MASTER_RR_EN undefined: fixed write priority, as described in Operation.

## Structure
- Shared package ddr_pkg holds:
  - FSM state encoding.
  - DDR_DATA_W=32, DDR_BE_ALL=4'hF.
  - Default BURST, ADDR_W and REGION_WORDS.
- One sub-module, ddr_addr_stream, instantiated twice (read and write). Its ports: base latch, offset counter, wrap, reload, advance.

## Test plan
- Write burst: wf_ready=1, wr_start_addr=0x100, local_ready=1, wf_q=1,2,3,4 -> address 0x100, burstbegin on beat 1 only, 4 pops, wr_addr_up pulse; the next burst uses 0x104.
- Read burst: rf_room=1, rd_start_addr=0x200, four local_rdata_valid beats with 0xA0..0xA3 -> one read_req at 0x200, rf_wrreq×4 each delayed 1 cycle with data 0xA0..0xA3, rd_addr_up pulse.
- Backpressure: local_ready toggling 1,0,1,0 during a write -> wf_rdreq only on ready cycles, exactly 4 pops, burstbegin held until the first accept.
- Wrap: REGION_WORDS=8, base 0x10, three write bursts -> addresses 0x10, 0x14, 0x10.
- Contention: wf_ready=rf_room=1 continuously -> without RR macro, writes only; with DDR_BURST_MASTER_RR_EN, the order is write, read, write, read.
- start pulse mid write burst -> burst finishes at its old address; the next burst uses the new base with offset 0. local_init_done=0 -> no requests issued.
